fp_accum_seq: RTL
=================

# fp_accum_seq

Operand sequencer and accumulator placed directly upstream of the multi-cycle FP adder (`fpadd`). It accepts a packet of IEEE-754 single-precision words over a valid/ready stream. It issues one `start`/`done` transaction on the adder per element after the first, keeping the running sum in a local register. When the last element has been added, it presents the packet sum, the element count and a timeout flag on an output valid/ready stream.

## Interface
- `CNT_W`, 8: width of the element counter; the count saturates at 2^CNT_W−1.
- `TIMEOUT`, 512: maximum number of WAIT cycles allowed per adder transaction (must be ≥ 2).
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_valid` in 1: an input element is present.
- `in_ready` out 1: the block can take an element; high only in ACCEPT.
- `in_data` in 32: FP32 element.
- `in_last` in 1: the element is the last one of its packet.
- `out_valid` out 1: the result is present; high only in OUT.
- `out_ready` in 1: the consumer takes the result.
- `out_data` out 32: FP32 packet sum.
- `out_count` out CNT_W: number of elements successfully accumulated.
- `out_err` out 1: an adder transaction timed out during this packet.
- `add_start` out 1: one-cycle start pulse to the adder.
- `add_a`, `add_b` out 32: adder operands (accumulator, held element).
- `add_sum` in 32: adder result.
- `add_done` in 1: adder result is valid; sticky until the next start.

## Operation
- Registers: `state`, `acc`[31:0], `b_reg`[31:0], `last_reg`, `cnt`[CNT_W-1:0], `err`, `timer`[clog2(TIMEOUT)-1:0].
- Outputs are decoded from registers only:
  - `in_ready` = (state==ACCEPT), `out_valid` = (state==OUT), `add_start` = (state==ISSUE).
  - `add_a` = `acc`, `add_b` = `b_reg`, `out_data` = `acc`, `out_count` = `cnt`, `out_err` = `err`.
- State transitions:
  - **IDLE**: the reset state; moves unconditionally to ACCEPT on the next edge.
  - **ACCEPT**, on a transfer (in_valid & in_ready): `b_reg`←`in_data`, `last_reg`←`in_last`.
    - If `cnt`==0 (first element): `acc`←`in_data`, `cnt`←1, with no adder transaction. Go to OUT if `in_last`, else stay in ACCEPT.
    - Otherwise go to ISSUE.
  - **ACCEPT**, no transfer: hold.
  - **ISSUE**: asserts `add_start` for exactly one cycle; `timer`←0; go to WAIT.
  - **WAIT**:
    - If `add_done`: `acc`←`add_sum`, `cnt`←sat(`cnt`+1); go to OUT if `last_reg`, else ACCEPT.
    - Else if `timer`==TIMEOUT−1: `err`←1, `acc` unchanged, `cnt` unchanged; go to OUT. The remainder of the packet is not consumed by this block.
    - Else `timer`←`timer`+1.
  - **OUT**: on `out_ready`: `acc`←0, `cnt`←0, `err`←0; go to ACCEPT.
- `add_done` is never sampled in ISSUE. The adder clears `done` on the edge at which it samples `start`, so any value seen in WAIT is fresh.
- NaN/Inf/zero handling is delegated entirely to the adder; this block does no FP decoding.
- After a timeout the adder may still be busy. The next ISSUE restarts it, because `start` overrides its state.
- The saturated count stays at 2^CNT_W−1; `acc` continues to accumulate.

## Timing
- Reset values:
  - state = IDLE, so `in_ready`=0, `out_valid`=0, `add_start`=0.
  - `acc`=`b_reg`=0, so `add_a`=`add_b`=`out_data`=0.
  - `cnt`=0, `out_count`=0, `err`=0, `out_err`=0, `timer`=0.
- `in_ready` rises one cycle after `reset` deasserts.
- Single-element packet: `out_valid` is high in the cycle after the transfer edge.
- Each subsequent element takes 1 ACCEPT cycle + 1 ISSUE cycle + L WAIT cycles, where L is the adder latency (done seen in WAIT cycle L).
- Timeout: `out_valid` is high TIMEOUT+1 cycles after ISSUE.
- `out_data`/`out_count`/`out_err` are stable while `out_valid`=1 and `out_ready`=0. `in_ready`=0 throughout OUT.
- `add_a`/`add_b` are stable from ISSUE through WAIT.
- Reset asserted mid-operation (any state) immediately returns all registers to reset values. `add_start` drops asynchronously and the partial packet is discarded. The adder's own synchronous reset is driven from the same `reset` net at top level.

## Test plan
- Single element `0x3FC00000` (1.5) with `in_last` → `out_data`=`0x3FC00000`, `out_count`=1, `out_err`=0, zero `add_start` pulses.
- Packet 1.0, 2.0, 3.0 (`0x3F800000`, `0x40000000`, `0x40400000`, last on third) with the real `fpadd` → `out_data`=`0x40C00000`, `out_count`=3, exactly 2 `add_start` pulses, each one cycle wide.
- Packet 1.0, −1.0 (`0xBF800000`) → `out_data`=`0x00000000`, `out_count`=2.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_valid`/`out_data` constant, `in_ready`=0. Then `out_ready`=1 → `in_ready`=1 next cycle, `out_count` 0.
- Timeout: TIMEOUT=16, adder model never raises `done`, packet 2.0, 5.0 → `out_valid` exactly 17 cycles after ISSUE, `out_err`=1, `out_data`=`0x40000000`, `out_count`=1.
- Assert `reset` during WAIT of a 3-element packet → all outputs 0 in the same cycle, `in_ready`=1 one cycle after release. A new packet 4.0, 4.0 then yields `0x41000000`, count 2.

Source files
------------

// File: rtl/fp_accum_seq_if.sv
// Stream and adder-side signal bundle for fp_accum_seq.
// slave: the accumulator block itself. master: its environment
// (element producer, result consumer and the FP adder).
interface fp_accum_seq_if #(
  parameter int CNT_W = 8
);
  // Input element stream
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  // Output result stream
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_err;
  // Adder transaction port
  logic             add_start;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             add_done;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, add_sum, add_done,
    output in_ready, out_valid, out_data, out_count, out_err,
           add_start, add_a, add_b
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, add_sum, add_done,
    input  in_ready, out_valid, out_data, out_count, out_err,
           add_start, add_a, add_b
  );
endinterface

// File: rtl/fp_accum_seq.sv
// Packet accumulator sequencing a multi-cycle FP32 adder. The first element
// of a packet seeds the accumulator; each later element is added through one
// start/done adder transaction. A per-transaction timeout aborts the packet
// and flags the result.
module fp_accum_seq #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 512
) (
  input logic          clk,
  input logic          reset,
  fp_accum_seq_if.slave bus
);
  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  state_t             state, state_d;
  logic [31:0]        acc, acc_d;
  logic [31:0]        b_reg, b_reg_d;
  logic               last_reg, last_reg_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               err, err_d;
  logic [TIMER_W-1:0] timer, timer_d;

  logic               in_xfer;
  logic [CNT_W-1:0]   cnt_inc;

  assign in_xfer = bus.in_valid && (state == ACCEPT);
  // Element count saturates at all-ones while acc keeps accumulating.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // Register-decoded outputs: no combinational path from any input.
  assign bus.in_ready  = (state == ACCEPT);
  assign bus.out_valid = (state == OUT);
  assign bus.add_start = (state == ISSUE);
  assign bus.add_a     = acc;
  assign bus.add_b     = b_reg;
  assign bus.out_data  = acc;
  assign bus.out_count = cnt;
  assign bus.out_err   = err;

  // State and datapath registers; async reset discards any partial packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      b_reg    <= '0;
      last_reg <= 1'b0;
      cnt      <= '0;
      err      <= 1'b0;
      timer    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state    <= state_d;
      acc      <= acc_d;
      b_reg    <= b_reg_d;
      last_reg <= last_reg_d;
      cnt      <= cnt_d;
      err      <= err_d;
      timer    <= timer_d;
    end
  end

  // Next-state and next-datapath decode.
  always_comb begin
    // NOTE: hold-value defaults first, so no path leaves a signal unassigned (no latches).
    state_d    = state;
    acc_d      = acc;
    b_reg_d    = b_reg;
    last_reg_d = last_reg;
    cnt_d      = cnt;
    err_d      = err;
    timer_d    = timer;

    unique case (state)
      IDLE: state_d = ACCEPT;

      ACCEPT: begin
        if (in_xfer) begin
          b_reg_d    = bus.in_data;
          last_reg_d = bus.in_last;
          if (cnt == '0) begin
            // First element seeds the sum without an adder transaction.
            acc_d   = bus.in_data;
            cnt_d   = CNT_W'(1);
            state_d = bus.in_last ? OUT : ACCEPT;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // done is cleared by the adder when it samples start, so it is fresh here.
        if (bus.add_done) begin
          acc_d   = bus.add_sum;
          cnt_d   = cnt_inc;
          state_d = last_reg ? OUT : ACCEPT;
        end else if (timer == TIMER_LAST) begin
          // Abort: report what was summed so far; rest of the packet is left unread.
          err_d   = 1'b1;
          state_d = OUT;
        end else begin
          timer_d = timer + 1'b1;
        end
      end

      OUT: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ACCEPT;
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule
